// File: rtl/dm_bus_arbiter_pkg.sv
// dm_bus_arbiter_pkg: shared debug-bus widths and arbiter state encodings
// Contents:
//   BUS_ADDR_WIDTH - DM hart-side bus address width (20)
//   DMREG_WIDTH    - DM register / bus data width (32)
//   HART_ID_WIDTH  - width of a hart index (up to 16 harts)
//   arb_state_e    - arbiter FSM states; ARB_RESP exists only with DM_ARB_RDATA_REG_EN
package dm_bus_arbiter_pkg;
  localparam int BUS_ADDR_WIDTH = 20;
  localparam int DMREG_WIDTH = 32;
  localparam int HART_ID_WIDTH = 4;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;
endpackage

// File: rtl/dm_bus_arbiter_if.sv
// dm_bus_arbiter_if: N-lane valid/ready debug bus with a shared read-data return
// Signals (one bit / slice per lane, lane i uses slice i):
//   valid  [N]       request valid, driven by the master
//   ready  [N]       completion pulse, driven by the slave
//   write  [N]       write flag
//   addr   [N*20]    address
//   wdata  [N*32]    write data
//   rdata  [32]      read data, shared by all lanes, valid with that lane's ready
// Modports: master (request side), slave (response side).
interface dm_bus_arbiter_if
  import dm_bus_arbiter_pkg::*;
#(
  parameter int N = 1
) ();
  logic [N-1:0] valid;
  logic [N-1:0] ready;
  logic [N-1:0] write;
  logic [N*BUS_ADDR_WIDTH-1:0] addr;
  logic [N*DMREG_WIDTH-1:0] wdata;
  logic [DMREG_WIDTH-1:0] rdata;
  modport master(output valid, write, addr, wdata, input ready, rdata);
  modport slave(input valid, write, addr, wdata, output ready, rdata);
endinterface

// File: rtl/dm_bus_arbiter_rr_pick.sv
// dm_rr_pick: combinational round-robin selector, first requester at or after (last+1) mod N
// Ports:
//   req  in  N  request vector
//   last in  4  index of the previously granted requester
//   any  out 1  at least one request pending
//   idx  out 4  selected requester (0 when no request)
module dm_rr_pick
  import dm_bus_arbiter_pkg::*;
#(
  parameter int N = 1
) (
  input  logic [N-1:0]             req,
  input  logic [HART_ID_WIDTH-1:0] last,
  output logic                     any,
  output logic [HART_ID_WIDTH-1:0] idx
);
  int best;
  int rank;
  // rank 0 is the requester right after last; the lowest-ranked requester wins
  always_comb begin
    any = |req;
    idx = '0;
    best = N;
    rank = 0;
    for (int j = 0; j < N; j++) begin
      rank = (j + N - 1 - (int'(last) % N)) % N;
      if (req[j] && rank < best) begin
        best = rank;
        idx = HART_ID_WIDTH'(j);
      end
    end
  end
endmodule

// File: rtl/dm_bus_arbiter.sv
// dm_bus_arbiter: round-robin sharing of the DM hart-side bus slave port among NUM_HART harts
// Parameters:
//   NUM_HART  number of hart master ports, 1..16
// Ports:
//   clk       in   clock
//   resetn    in   synchronous, active-low reset
//   m         slave modport of an N=NUM_HART bus: hart requests in, m.ready pulse / m.rdata out
//   s         master modport of an N=1 bus: request to the DM, DM ready/rdata back
//   grant_id  out  index of the hart owning the DM port; holds its last value while idle
// Configuration:
//   DM_ARB_RDATA_REG_EN  when defined, m.ready/m.rdata are registered and issued from an
//                        extra RESP state one cycle after the DM handshake; otherwise they are
//                        combinational from s.ready/s.rdata.
module dm_bus_arbiter
  import dm_bus_arbiter_pkg::*;
#(
  parameter int NUM_HART = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  dm_bus_arbiter_if.slave          m,
  dm_bus_arbiter_if.master         s,
  output logic [HART_ID_WIDTH-1:0] grant_id
);
  arb_state_e state, state_nx;
  logic [HART_ID_WIDTH-1:0] last, pick;
  logic any, fire, rsp;
  logic [NUM_HART-1:0] gnt_oh;
  logic write_q, cap_write;
  logic [BUS_ADDR_WIDTH-1:0] addr_q, cap_addr;
  logic [DMREG_WIDTH-1:0] wdata_q, cap_wdata, rsp_data;

  dm_rr_pick #(.N(NUM_HART)) u_pick (
    .req (m.valid),
    .last(last),
    .any (any),
    .idx (pick)
  );

  assign gnt_oh = NUM_HART'(1) << grant_id;
  // resetn gates the handshake so a transaction caught by reset never reports completion
  assign fire = resetn && state == ARB_BUSY && s.ready;
  assign s.valid = state == ARB_BUSY;
  assign s.write = write_q;
  assign s.addr = addr_q;
  assign s.wdata = wdata_q;
  assign m.ready = rsp ? gnt_oh : '0;
  assign m.rdata = rsp ? rsp_data : '0;

  always_comb begin
    cap_write = 1'b0;
    cap_addr = '0;
    cap_wdata = '0;
    for (int i = 0; i < NUM_HART; i++) begin
      if (pick == HART_ID_WIDTH'(i)) begin
        cap_write = m.write[i];
        cap_addr = m.addr[i*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH];
        cap_wdata = m.wdata[i*DMREG_WIDTH +: DMREG_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) state <= !resetn ? ARB_IDLE : state_nx;

  // the request is frozen at grant so upstream changes while BUSY cannot reach the DM
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last <= HART_ID_WIDTH'(NUM_HART - 1);
      grant_id <= '0;
      write_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else if (state == ARB_IDLE && any) begin
      last <= pick;
      grant_id <= pick;
      write_q <= cap_write;
      addr_q <= cap_addr;
      wdata_q <= cap_wdata;
    end
  end

`ifdef DM_ARB_RDATA_REG_EN
  logic [DMREG_WIDTH-1:0] rdata_q;
  always_ff @(posedge clk) rdata_q <= !resetn ? '0 : fire ? s.rdata : rdata_q;
  always_comb begin
    state_nx = state;
    state_nx = state == ARB_IDLE ? (any ? ARB_BUSY : ARB_IDLE) :
               state == ARB_BUSY ? (s.ready ? ARB_RESP : ARB_BUSY) : ARB_IDLE;
    rsp = resetn && state == ARB_RESP;
    rsp_data = rdata_q;
  end
`else
  always_comb begin
    state_nx = state;
    state_nx = state == ARB_IDLE ? (any ? ARB_BUSY : ARB_IDLE) :
               (s.ready ? ARB_IDLE : ARB_BUSY);
    rsp = fire;
    rsp_data = s.rdata;
  end
`endif
endmodule

// File: tb/tb_dm_bus_arbiter.sv
// tb_dm_bus_arbiter: self-checking bench for dm_bus_arbiter with a 1-cycle-ready DM model
module tb_dm_bus_arbiter;
  import dm_bus_arbiter_pkg::*;
  localparam int N = 4;
  localparam logic [31:0] ROM = 32'h0ff0000f;
`ifdef DM_ARB_RDATA_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  typedef struct {
    int h;
    bit w;
    logic [19:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [3:0] grant_id;
  logic dm_ready = 1'b0;
  logic [31:0] mem [256] = '{default: 32'h0};
  logic [31:0] ref_mem [8];
  bit cw [N];
  logic [19:0] ca [N];
  logic [31:0] cd [N];
  int passed = 0;
  int total = 0;

  dm_bus_arbiter_if #(.N(N)) mb ();
  dm_bus_arbiter_if #(.N(1)) sb ();

  dm_bus_arbiter #(.NUM_HART(N)) dut (
    .clk(clk),
    .resetn(resetn),
    .m(mb),
    .s(sb),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // DM model: ready one cycle after valid, dropped after each handshake; address 0 is ROM
  always @(posedge clk) begin
    if (!resetn) dm_ready <= 1'b0;
    else begin
      dm_ready <= sb.valid[0] && !dm_ready;
      if (sb.valid[0] && dm_ready && sb.write[0]) mem[sb.addr[7:0]] <= sb.wdata;
    end
  end
  assign sb.ready = dm_ready;
  assign sb.rdata = (dm_ready && !sb.write[0]) ? (sb.addr == 20'h0 ? ROM : mem[sb.addr[7:0]]) : 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic set_req(input int h, input bit w, input logic [19:0] a, input logic [31:0] d);
    cw[h] = w;
    ca[h] = a;
    cd[h] = d;
    mb.valid[h] = 1'b1;
    mb.write[h] = w;
    mb.addr[h*20 +: 20] = a;
    mb.wdata[h*32 +: 32] = d;
  endtask

  task automatic new_req(input int h);
    bit w;
    logic [19:0] a;
    w = 1'($urandom_range(1));
    a = 20'h40 + 20'($urandom_range(7));
    if (!w && $urandom_range(8) == 0) a = 20'h0;
    set_req(h, w, a, $urandom);
  endtask

  task automatic do_reset();
    mb.valid = '0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  function automatic int rr(input logic [N-1:0] req, input int lst);
    for (int k = 1; k <= N; k++) if (req[(lst + k) % N]) return (lst + k) % N;
    return -1;
  endfunction

  task automatic txn(input vec_t v);
    int lat = 0;
    logic [31:0] rd = 32'h0;
    @(posedge clk);
    #1 set_req(v.h, v.w, v.a, v.d);
    @(negedge clk);
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("busy_valid", 32'(sb.valid), 1);
        chk("grant_id", 32'(grant_id), 32'(v.h));
        chk("s_addr", 32'(sb.addr), 32'(v.a));
        chk("s_write", 32'(sb.write), 32'(v.w));
        if (v.w) chk("s_wdata", sb.wdata, v.d);
      end
      if (mb.ready != 0) begin
        lat = c;
        rd = mb.rdata;
        chk("ready_vec", 32'(mb.ready), 32'(1) << v.h);
      end
    end
    chk("latency", lat, LAT);
    if (!v.w) chk("rdata", rd, v.exp);
    @(posedge clk);
    #1 mb.valid[v.h] = 1'b0;
    @(negedge clk);
    chk("idle_valid", 32'(sb.valid), 0);
    chk("idle_ready", 32'(mb.ready), 0);
    chk("idle_rdata", mb.rdata, 0);
  endtask

  task automatic wait_rdy(input int h, output bit ok, output logic [31:0] rd);
    ok = 1'b0;
    rd = 32'h0;
    for (int c = 0; c < 10 && !ok; c++) begin
      if (mb.ready[h]) begin
        ok = 1'b1;
        rd = mb.rdata;
      end else @(negedge clk);
    end
    @(posedge clk);
    #1 mb.valid[h] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    int order[$];
    int cnt[N];
    int ov, bad, seq, g, due, free_at, cyc;
    bit pend, ok;
    logic [31:0] rd, exp_rdy;
    logic [N-1:0] drop, done;
    tbl[0] = '{1, 1'b0, 20'h00000, 32'h0, ROM};
    tbl[1] = '{2, 1'b1, 20'h00010, 32'h12345678, 32'h0};
    tbl[2] = '{0, 1'b0, 20'h00010, 32'h0, 32'h12345678};
    tbl[3] = '{3, 1'b1, 20'h00014, 32'hdeadbeef, 32'h0};
    tbl[4] = '{3, 1'b0, 20'h00014, 32'h0, 32'hdeadbeef};
    tbl[5] = '{1, 1'b0, 20'h00010, 32'h0, 32'h12345678};
    tbl[6] = '{2, 1'b0, 20'h00000, 32'h0, ROM};
    mb.valid = '0;
    mb.write = '0;
    mb.addr = '0;
    mb.wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_valid", 32'(sb.valid), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_m_ready", 32'(mb.ready), 0);
    chk("rst_m_rdata", mb.rdata, 0);
    chk("rst_s_addr", 32'(sb.addr), 0);
    chk("rst_s_wdata", sb.wdata, 0);
    chk("rst_s_write", 32'(sb.write), 0);
    @(posedge clk);
    #1 resetn = 1'b1;

    foreach (tbl[i]) txn(tbl[i]);

    // harts 0 and 1 together from reset: 0 first, then 1, never overlapping
    do_reset();
    set_req(0, 1'b0, 20'h00010, 32'h0);
    set_req(1, 1'b0, 20'h00000, 32'h0);
    ov = 0;
    for (int c = 0; c < 30 && order.size() < 2; c++) begin
      @(negedge clk);
      if ($countones(mb.ready) > 1) ov++;
      for (int h = 0; h < N; h++) if (mb.ready[h]) order.push_back(h);
      drop = mb.ready;
      @(posedge clk);
      #1 mb.valid = mb.valid & ~drop;
    end
    chk("contend_count", order.size(), 2);
    chk("contend_first", order.size() > 0 ? order[0] : 99, 0);
    chk("contend_second", order.size() > 1 ? order[1] : 99, 1);
    chk("contend_overlap", ov, 0);

    // request changes while BUSY must not reach the DM
    @(posedge clk);
    #1 set_req(2, 1'b1, 20'h00020, 32'ha5a5a5a5);
    @(negedge clk);
    @(negedge clk);
    chk("hold_valid", 32'(sb.valid), 1);
    mb.addr[2*20 +: 20] = 20'h00030;
    mb.wdata[2*32 +: 32] = 32'h5a5a5a5a;
    @(negedge clk);
    chk("hold_addr", 32'(sb.addr), 32'h20);
    chk("hold_wdata", sb.wdata, 32'ha5a5a5a5);
    wait_rdy(2, ok, rd);
    chk("hold_done", 32'(ok), 1);
    txn('{0, 1'b0, 20'h00020, 32'h0, 32'ha5a5a5a5});
    txn('{3, 1'b0, 20'h00030, 32'h0, 32'h0});

    // granted master drops valid mid-transaction: completion still pulses
    @(posedge clk);
    #1 set_req(3, 1'b0, 20'h00000, 32'h0);
    @(negedge clk);
    @(negedge clk);
    mb.valid[3] = 1'b0;
    wait_rdy(3, ok, rd);
    chk("drop_done", 32'(ok), 1);
    chk("drop_rdata", rd, ROM);
    @(negedge clk);
    chk("drop_after", 32'(sb.valid), 0);

    // reset while s_valid is high abandons the transaction; hart 0 wins afterwards
    @(posedge clk);
    #1 set_req(1, 1'b0, 20'h00010, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("mrst_valid", 32'(sb.valid), 1);
    chk("mrst_grant", 32'(grant_id), 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("mrst_s_valid", 32'(sb.valid), 0);
    chk("mrst_m_ready", 32'(mb.ready), 0);
    chk("mrst_grant0", 32'(grant_id), 0);
    mb.valid = '0;
    set_req(0, 1'b0, 20'h00010, 32'h0);
    set_req(2, 1'b0, 20'h00010, 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    chk("mrst_first_grant", 32'(grant_id), 0);
    chk("mrst_first_valid", 32'(sb.valid), 1);

    // fairness: all harts request continuously
    do_reset();
    for (int h = 0; h < N; h++) set_req(h, 1'b0, 20'h00000, 32'h0);
    bad = 0;
    seq = 0;
    foreach (cnt[h]) cnt[h] = 0;
    for (int c = 0; c < 300 && seq < 40; c++) begin
      @(negedge clk);
      for (int h = 0; h < N; h++) if (mb.ready[h]) begin
        cnt[h]++;
        if (h != seq % N) bad++;
        seq++;
      end
    end
    chk("fair_total", seq, 40);
    chk("fair_order", bad, 0);
    for (int h = 0; h < N; h++) chk("fair_count", cnt[h], 10);

    // randomized traffic against a cycle-level round-robin reference
    do_reset();
    foreach (ref_mem[i]) ref_mem[i] = 32'h0;
    g = 0;
    due = 0;
    free_at = 0;
    cyc = 0;
    pend = 1'b0;
    seq = N - 1;
    done = '0;
    for (int i = 0; i < 600; i++) begin
      for (int h = 0; h < N; h++) begin
        if (done[h]) begin
          if ($urandom_range(1) == 1) new_req(h);
          else mb.valid[h] = 1'b0;
        end else if (!mb.valid[h] && $urandom_range(2) == 0) new_req(h);
      end
      @(negedge clk);
      cyc++;
      exp_rdy = (pend && cyc == due) ? 32'(1) << g : 32'h0;
      chk("rand_ready", 32'(mb.ready), exp_rdy);
      if (pend && cyc == due) begin
        pend = 1'b0;
        if (cw[g]) ref_mem[ca[g][2:0]] = cd[g];
        else chk("rand_rdata", mb.rdata, ca[g] == 20'h0 ? ROM : ref_mem[ca[g][2:0]]);
      end
      if (!pend && cyc >= free_at && mb.valid != '0) begin
        g = rr(mb.valid, seq);
        seq = g;
        due = cyc + LAT;
        free_at = due + 1;
        pend = 1'b1;
      end
      done = mb.ready;
      @(posedge clk);
      #1;
    end
    do_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
